// File: rtl/microcode_pkg.sv
// Shared definitions for the control-store loader and the sequencer that reads the store.
// Microword layout (LSB first): Z, Y, X, CNState, PolarityBit, InputSelect.
package microcode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_WHI,
    ST_WLO,
    ST_CSUM,
    ST_FIN,
    ST_ERR
  } mcload_state_e;

  localparam logic [7:0] MC_HEADER = 8'hA5;

  localparam int MC_Z_LSB       = 0;
  localparam int MC_Z_W         = 1;
  localparam int MC_Y_LSB       = 1;
  localparam int MC_Y_W         = 1;
  localparam int MC_X_LSB       = 2;
  localparam int MC_X_W         = 1;
  localparam int MC_CNSTATE_LSB = 3;
  localparam int MC_CNSTATE_W   = 3;
  localparam int MC_POL_LSB     = 6;
  localparam int MC_POL_W       = 1;
  localparam int MC_INSEL_LSB   = 7;
  localparam int MC_INSEL_W     = 3;

  // A received 16-bit word is usable only when every bit above the microword is zero.
  function automatic logic pad_clear(input logic [15:0] w, input int unsigned word_w);
    return (w >> word_w) == 16'd0;
  endfunction

endpackage

// File: rtl/mcload_word_asm.sv
// Pairs stream bytes into a microword, checks the padding bits and, when
// MCLOAD_CHECKSUM_EN is defined, keeps the running XOR of the frame bytes.
module mcload_word_asm
  import microcode_pkg::*;
#(
  parameter int WORD_W = 10
) (
  input  logic              clk_i,
  input  logic              hi_load_i,
  input  logic [7:0]        byte_i,
`ifdef MCLOAD_CHECKSUM_EN
  input  logic              acc_clr_i,
  input  logic              acc_en_i,
  output logic [7:0]        acc_o,
`endif
  output logic [WORD_W-1:0] word_o,
  output logic              pad_ok_o
);

  logic [7:0]  hi_q;
  logic [15:0] word16;

  always_ff @(posedge clk_i) begin
    if (hi_load_i) hi_q <= byte_i;
  end

  // The low byte is used straight from the stream so the word is ready in the WLO cycle.
  assign word16   = {hi_q, byte_i};
  assign word_o   = word16[WORD_W-1:0];
  assign pad_ok_o = pad_clear(word16, WORD_W);

`ifdef MCLOAD_CHECKSUM_EN
  logic [7:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (acc_clr_i)     acc_q <= 8'd0;
    else if (acc_en_i) acc_q <= acc_q ^ byte_i;
  end

  assign acc_o = acc_q;
`endif

endmodule

// File: rtl/microcode_loader.sv
// Parses a framed byte stream and writes the control store; holds the sequencer until a full image lands.
// Optional trailing checksum byte is built when MCLOAD_CHECKSUM_EN is defined.
module microcode_loader
  import microcode_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              seq_hold_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  mcload_state_e state_q, state_d;

  logic              xfer;
  logic              count_ok;
  logic              last_word;
  logic              pad_ok;
  logic              wr_fire;
  logic [WORD_W-1:0] word;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     idx_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;
  logic              seq_hold_q;
  logic              error_q;

  assign xfer      = in_valid_i && in_ready_o;
  assign count_ok  = (in_data_i != 8'd0) && (int'(in_data_i) <= DEPTH);
  assign last_word = (idx_q + CW'(1)) == cnt_q;
  assign wr_fire   = (state_q == ST_WLO) && xfer && pad_ok;

`ifdef MCLOAD_CHECKSUM_EN
  logic [7:0] acc;
`endif

  mcload_word_asm #(.WORD_W(WORD_W)) u_word_asm (
    .clk_i     (clk_i),
    .hi_load_i ((state_q == ST_WHI) && xfer),
    .byte_i    (in_data_i),
`ifdef MCLOAD_CHECKSUM_EN
    .acc_clr_i ((state_q == ST_IDLE) && start_i),
    .acc_en_i  (xfer && ((state_q == ST_CNT) || (state_q == ST_WHI) || (state_q == ST_WLO))),
    .acc_o     (acc),
`endif
    .word_o    (word),
    .pad_ok_o  (pad_ok)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_HDR;
      ST_HDR:  if (xfer) state_d = (in_data_i == MC_HEADER) ? ST_CNT : ST_ERR;
      ST_CNT:  if (xfer) state_d = count_ok ? ST_WHI : ST_ERR;
      ST_WHI:  if (xfer) state_d = ST_WLO;
      ST_WLO: begin
        if (xfer) begin
          if (!pad_ok)        state_d = ST_ERR;
`ifdef MCLOAD_CHECKSUM_EN
          else if (last_word) state_d = ST_CSUM;
`else
          else if (last_word) state_d = ST_FIN;
`endif
          else                state_d = ST_WHI;
        end
      end
`ifdef MCLOAD_CHECKSUM_EN
      ST_CSUM: if (xfer) state_d = (in_data_i == acc) ? ST_FIN : ST_ERR;
`endif
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_HDR, ST_CNT, ST_WHI, ST_WLO, ST_CSUM: in_ready_o = 1'b1;
      ST_FIN:                                  done_o     = 1'b1;
      default: ;
    endcase
  end

  // SeqHold drops on the edge entering FIN so it falls together with Done; an error leaves it high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      seq_hold_q <= 1'b1;
      error_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      wr_en_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= idx_q[ADDR_W-1:0];
        wr_data_q <= word;
        idx_q     <= idx_q + CW'(1);
      end
      if ((state_q == ST_IDLE) && start_i) begin
        error_q    <= 1'b0;
        seq_hold_q <= 1'b1;
        idx_q      <= '0;
      end
      if ((state_q == ST_CNT) && xfer && count_ok) cnt_q <= CW'(in_data_i);
      if (state_d == ST_FIN) seq_hold_q <= 1'b0;
      if (state_d == ST_ERR) error_q    <= 1'b1;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign seq_hold_o = seq_hold_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_microcode_loader.sv
// Directed bench for microcode_loader (ADDR_W=3, WORD_W=10); follows MCLOAD_CHECKSUM_EN for the trailing byte.
module tb_microcode_loader;

  localparam int ADDR_W = 3;
  localparam int WORD_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              seq_hold;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  microcode_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .seq_hold_o (seq_hold),
    .done_o     (done),
    .error_o    (error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int wr_count     = 0;
  int done_count   = 0;
  int hold_at_done = 0;
  logic [ADDR_W-1:0] log_addr [256];
  logic [WORD_W-1:0] log_data [256];

  logic [15:0] img [8] = '{16'h03C4, 16'h0048, 16'h00B0, 16'h015E,
                           16'h03C2, 16'h0382, 16'h01B5, 16'h03C1};

  // Records every control-store write and every Done cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      log_addr[wr_count[7:0]] <= wr_addr;
      log_data[wr_count[7:0]] <= wr_data;
      wr_count <= wr_count + 1;
    end
    if (done) begin
      done_count <= done_count + 1;
      if (seq_hold) hold_at_done <= hold_at_done + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int guard;
    int gaps;
    guard = 0;
    if (thr) begin
      gaps = int'($urandom_range(0, 2));
      repeat (gaps) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      $error("FAIL send_timeout observed=%0d expected=1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_words(input bit thr);
    start_pulse();
    send_byte(8'hA5, thr);
    send_byte(8'h08, thr);
    for (int k = 0; k < 8; k++) begin
      send_byte(img[k][15:8], thr);
      send_byte(img[k][7:0], thr);
    end
  endtask

  task automatic check_image(input int base, input string tag);
    chk({tag, "_wr_count"}, 32'(wr_count - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 32'(log_addr[base + k]), 32'(k));
      chk($sformatf("%s_data%0d", tag, k), 32'(log_data[base + k]), 32'(img[k]));
    end
  endtask

  initial begin
    int base;
    int d0;
    int h0;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_error",    32'(error),    32'd0);
    chk("rst_seq_hold", 32'(seq_hold), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Good frame at full rate.
    base = wr_count; d0 = done_count; h0 = hold_at_done;
    send_words(1'b0);
`ifdef MCLOAD_CHECKSUM_EN
    send_byte(8'h5E, 1'b0);
`endif
    settle();
    check_image(base, "good");
    chk("good_done_cycles",   32'(done_count - d0),   32'd1);
    chk("good_hold_at_done",  32'(hold_at_done - h0), 32'd0);
    chk("good_seq_hold_low",  32'(seq_hold),          32'd0);
    chk("good_error",         32'(error),             32'd0);

    // Bad header.
    base = wr_count; d0 = done_count;
    start_pulse();
    chk("hdr_seq_hold_set", 32'(seq_hold), 32'd1);
    send_byte(8'h5A, 1'b0);
    settle();
    chk("hdr_error",    32'(error),             32'd1);
    chk("hdr_writes",   32'(wr_count - base),   32'd0);
    chk("hdr_seq_hold", 32'(seq_hold),          32'd1);
    chk("hdr_done",     32'(done_count - d0),   32'd0);

    // Count 0x00, then count 0x09.
    base = wr_count;
    start_pulse();
    chk("err_cleared_by_start", 32'(error), 32'd0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    settle();
    chk("cnt0_error",  32'(error),           32'd1);
    chk("cnt0_writes", 32'(wr_count - base), 32'd0);
    base = wr_count;
    start_pulse();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h09, 1'b0);
    settle();
    chk("cnt9_error",  32'(error),           32'd1);
    chk("cnt9_writes", 32'(wr_count - base), 32'd0);

    // Padding violation on the second word.
    base = wr_count;
    start_pulse();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hC4, 1'b0);
    send_byte(8'h04, 1'b0);
    chk("pad_no_error_before_lo", 32'(error), 32'd0);
    send_byte(8'h00, 1'b0);
    settle();
    chk("pad_error",    32'(error),            32'd1);
    chk("pad_writes",   32'(wr_count - base),  32'd1);
    chk("pad_addr0",    32'(log_addr[base]),   32'd0);
    chk("pad_data0",    32'(log_data[base]),   32'h3C4);
    chk("pad_seq_hold", 32'(seq_hold),         32'd1);

    // Throttled good frame.
    base = wr_count; d0 = done_count;
    send_words(1'b1);
`ifdef MCLOAD_CHECKSUM_EN
    send_byte(8'h5E, 1'b1);
`endif
    settle();
    check_image(base, "thr");
    chk("thr_done_cycles", 32'(done_count - d0), 32'd1);
    chk("thr_seq_hold",    32'(seq_hold),        32'd0);

`ifdef MCLOAD_CHECKSUM_EN
    // Wrong checksum.
    base = wr_count; d0 = done_count;
    send_words(1'b0);
    send_byte(8'h5F, 1'b0);
    settle();
    chk("csum_error",    32'(error),            32'd1);
    chk("csum_seq_hold", 32'(seq_hold),         32'd1);
    chk("csum_done",     32'(done_count - d0),  32'd0);
    chk("csum_writes",   32'(wr_count - base),  32'd8);
`endif

    // Reset in the middle of the third word.
    base = wr_count; d0 = done_count;
    start_pulse();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h08, 1'b0);
    for (int k = 0; k < 2; k++) begin
      send_byte(img[k][15:8], 1'b0);
      send_byte(img[k][7:0], 1'b0);
    end
    send_byte(img[2][15:8], 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = img[2][7:0];
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_writes",   32'(wr_count - base), 32'd2);
    chk("rstmid_in_ready", 32'(in_ready),        32'd0);
    chk("rstmid_seq_hold", 32'(seq_hold),        32'd1);
    chk("rstmid_done",     32'(done_count - d0), 32'd0);
    chk("rstmid_error",    32'(error),           32'd0);

    base = wr_count; d0 = done_count;
    send_words(1'b0);
`ifdef MCLOAD_CHECKSUM_EN
    send_byte(8'h5E, 1'b0);
`endif
    settle();
    check_image(base, "after_rst");
    chk("after_rst_done", 32'(done_count - d0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/microcode_loader.md
# microcode_loader

Loads the writable control store of the microcoded state machine from a byte stream. It parses a framed image and writes one microword per cycle into the control store, starting at address 0. It holds the sequencer in reset until a complete, valid image has been written. It is the writer side of the control store; the sequencer is the reader.

## Interface
- ADDR_W, 3: control-store address width; depth is 2^ADDR_W words.
- WORD_W, 10: microword width, 9..16. Fields are {InputSelect, PolarityBit, CNState, X, Y, Z}.
- Clock  in  1  system clock; every action occurs on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- InValid  in  1  a byte is present on InData.
- InData  in  8  stream byte.
- InReady  out  1  loader accepts a byte this cycle; a transfer occurs when InValid && InReady.
- WrEn  out  1  control-store write strobe.
- WrAddr  out  ADDR_W  write address.
- WrData  out  WORD_W  write data.
- SeqHold  out  1  holds the sequencer State register at 0 while high.
- Done  out  1  one-cycle pulse when a load completes successfully.
- Error  out  1  sticky error flag; cleared by the next accepted Start.

## Operation
- Frame format: 0xA5 header, count byte N, then N words, then a checksum byte when configured.
- Each word is 2 bytes, high byte first.
- Word value is {hi, lo}[WORD_W-1:0]. Bits [15:WORD_W] must be 0.
- Checksum is the XOR of the count byte and all word bytes.
- FSM states: IDLE, HDR, CNT, WHI, WLO, CSUM, FIN, ERR.
- IDLE:
  - InReady=0.
  - Start → HDR. Error is cleared, SeqHold is set to 1, and the word counter is set to 0.
- HDR:
  - Byte == 0xA5 → CNT.
  - Any other byte → ERR.
- CNT:
  - Valid N is 1..2^ADDR_W; N is latched → WHI.
  - N == 0 or N > 2^ADDR_W → ERR.
- WHI: the high byte is latched → WLO.
- WLO:
  - If the padding bits are nonzero → ERR.
  - Otherwise a write is issued.
  - Next state is WHI if words remain. When the last word is written, next state is CSUM with the macro defined, or FIN without it.
- CSUM:
  - Byte equals the running XOR → FIN.
  - Otherwise → ERR.
- FIN: Done=1 and SeqHold=0 → IDLE.
- ERR: Error=1; SeqHold stays 1 → IDLE.
- InReady is 1 in HDR, CNT, WHI, WLO and CSUM, and 0 in all other states.
- A Start that arrives outside IDLE is ignored; it does not abort the current load.
- Words already written before an error remain in the store. Because SeqHold stays 1 after an error, the sequencer never runs a partial image.
- Reset values:
  - State IDLE.
  - InReady=0, WrEn=0, WrAddr=0, WrData=0, Done=0, Error=0.
  - SeqHold=1: the control-store contents are undefined after reset.
- Reset during a load abandons the frame. The state returns to IDLE with SeqHold=1, and no further writes are issued.

## Timing
- A byte is accepted in the cycle where InValid && InReady. State advances on that edge.
- The FSM stalls without limit while InValid=0, and no timeout exists.
- WrEn is a single registered pulse in the cycle after the low byte is accepted. WrAddr and WrData are valid in that same cycle.
- WrAddr for word k equals k. The counter is ADDR_W+1 bits wide so that N=2^ADDR_W is reached without wrap-around.
- Maximum sustained rate is 1 byte per cycle, so 1 word per 2 cycles.
- Done asserts 1 cycle after the final byte (checksum or last low byte) is accepted. SeqHold falls in the same cycle as Done.
- Error asserts 1 cycle after the offending byte is accepted and holds until the next accepted Start.

## Configuration
- MCLOAD_CHECKSUM_EN defined:
  - The CSUM state exists.
  - The frame carries a trailing checksum byte.
  - A mismatch → ERR.
- MCLOAD_CHECKSUM_EN undefined:
  - CSUM and the XOR accumulator are not built.
  - The frame ends after the last word, and WLO → FIN directly.

## Structure
- Package microcode_pkg holds:
  - the FSM state enum;
  - MC_HEADER = 8'hA5;
  - microword field widths and offsets for InputSelect, PolarityBit, CNState and X/Y/Z. The sequencer shares these.
- One natural sub-module is mcload_word_asm: it pairs bytes into a word, checks the padding bits and keeps the running XOR. The FSM stays in microcode_loader.

## Test plan
- Good frame, checksum on, ADDR_W=3: bytes A5, 08, then the 8 words 0x3C4, 0x048, 0x0B0, 0x15E, 0x3C2, 0x382, 0x1B5, 0x3C1, then the correct checksum.
  - Expect 8 WrEn pulses at addresses 0..7 with matching data.
  - Expect Done=1 for exactly 1 cycle and SeqHold to fall in that same cycle.
- Bad header 0x5A → Error=1, no WrEn, SeqHold=1.
- Count byte out of range:
  - Count 0x00 → Error=1.
  - Count 0x09 → Error=1.
  - In both cases no write occurs.
- Padding error: high byte 0x04 with WORD_W=10 → Error after the low byte, and no write for that word.
- Throttling and checksum failure:
  - InValid toggles randomly → the same writes occur, delayed, with nothing lost or duplicated.
  - Wrong checksum → Error=1 and SeqHold stays 1.
- Reset during the third word → no further WrEn, state IDLE, SeqHold=1. A following good frame loads normally.
